// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus controller.
//   state_e       : controller FSM states
//   DEF_*         : default geometry of the I/O window
//   SLOT_*        : named peripheral slot indices
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int          DATA_W        = 32;
  localparam int          DEF_N_PERIPH  = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_F000;
  localparam int          DEF_SLOT_BITS = 4;

  localparam int SLOT_LEDS     = 0;
  localparam int SLOT_SWITCHES = 1;
  localparam int SLOT_KEYS     = 2;
  localparam int SLOT_TIMER    = 3;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder for the MMIO window.
//   addr_i       : CPU byte address
//   hit_o        : address falls inside the N_PERIPH-slot window
//   idx_o        : slot index within the window
//   misaligned_o : address is not word aligned (addr[1:0] != 0)
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int          N_PERIPH  = DEF_N_PERIPH,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          SLOT_BITS = DEF_SLOT_BITS
) (
  input  logic [31:0]                   addr_i,
  output logic                          hit_o,
  output logic [$clog2(N_PERIPH)-1:0]   idx_o,
  output logic                          misaligned_o
);

  localparam int IDX_W   = $clog2(N_PERIPH);
  localparam int TAG_LSB = SLOT_BITS + IDX_W;

  localparam logic [31-TAG_LSB:0] BASE_TAG = BASE_ADDR[31:TAG_LSB];

  assign hit_o        = (addr_i[31:TAG_LSB] == BASE_TAG);
  assign idx_o        = addr_i[TAG_LSB-1:SLOT_BITS];
  assign misaligned_o = |addr_i[1:0];

  // Offset bits inside a slot carry no meaning for the decode.
  logic unused_addr;
  assign unused_addr = ^addr_i;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: accepts one CPU load/store at a time, strobes the
// decoded peripheral slot for one cycle and returns a single response pulse.
//   clk, reset_n            : clock, async active-low reset
//   cpu_req_valid/_ready    : request handshake (ready only in IDLE)
//   cpu_addr/write/wdata    : request payload
//   cpu_rsp_valid           : one-cycle response pulse
//   cpu_rdata, cpu_err      : response payload, held between responses
//   periph_cs/we/wdata      : one-cycle strobe to the selected slot
//   periph_rdata            : registered read data, slot i at [32i+31:32i]
// Optional: define MMIO_ALIGN_CHECK_EN to reject addresses with addr[1:0]!=0
// as unmapped.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int          N_PERIPH     = DEF_N_PERIPH,
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int          SLOT_BITS    = DEF_SLOT_BITS,
  parameter int          READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cpu_req_valid,
  output logic                       cpu_req_ready,
  input  logic [31:0]                cpu_addr,
  input  logic                       cpu_write,
  input  logic [31:0]                cpu_wdata,
  output logic                       cpu_rsp_valid,
  output logic [31:0]                cpu_rdata,
  output logic                       cpu_err,
  output logic [N_PERIPH-1:0]        periph_cs,
  output logic                       periph_we,
  output logic [31:0]                periph_wdata,
  input  logic [N_PERIPH*DATA_W-1:0] periph_rdata
);

  localparam int IDX_W = $clog2(N_PERIPH);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               dec_hit, dec_mis, acc_ok, issue;
  logic [IDX_W-1:0]   dec_idx;
  logic [31:0]        slot_rdata [N_PERIPH];

  mmio_addr_decode #(
    .N_PERIPH (N_PERIPH),
    .BASE_ADDR(BASE_ADDR),
    .SLOT_BITS(SLOT_BITS)
  ) u_dec (
    .addr_i      (cpu_addr),
    .hit_o       (dec_hit),
    .idx_o       (dec_idx),
    .misaligned_o(dec_mis)
  );

`ifdef MMIO_ALIGN_CHECK_EN
  assign acc_ok = dec_hit & ~dec_mis;
`else
  assign acc_ok = dec_hit;
  logic unused_mis;
  assign unused_mis = dec_mis;
`endif

  // Per-slot view of the flat read bus; chip select is a one-hot of idx_q,
  // asserted only while in ISSUE so reset drops it immediately.
  for (genvar g = 0; g < N_PERIPH; g++) begin : g_slot
    assign slot_rdata[g] = periph_rdata[DATA_W*g +: DATA_W];
    assign periph_cs[g]  = issue && (idx_q == IDX_W'(g));
  end

  assign issue         = (state_q == ISSUE);
  assign cpu_req_ready = (state_q == IDLE);
  assign cpu_rsp_valid = (state_q == RESP);
  assign periph_we     = issue & write_q;
  assign periph_wdata  = issue ? wdata_q : '0;
  assign cpu_rdata     = rdata_q;
  assign cpu_err       = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // rdata/err only change on the edge entering RESP, so they hold their
  // last value between responses.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          idx_d   = dec_idx;
          write_d = cpu_write;
          wdata_d = cpu_wdata;
          if (acc_ok) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Final wait cycle: peripheral data is valid now.
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          rdata_d = slot_rdata[idx_q];
          err_d   = 1'b0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: table of request vectors driven
// through a scoreboard, plus back-to-back and mid-operation reset sequences.
module tb_mmio_bus_ctrl;

  localparam int RL = 1;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  cs;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [31:0]  cpu_addr;
  logic         cpu_write;
  logic [31:0]  cpu_wdata;
  logic         cpu_rsp_valid;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [3:0]   periph_cs;
  logic         periph_we;
  logic [31:0]  periph_wdata;
  logic [127:0] periph_rdata;

  logic [31:0] rom [4] = '{32'h1111_0000, 32'h0000_00A5, 32'h2222_2222, 32'hF00D_BEEF};
  logic [31:0] prd [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, n_rsp = 0, n_cs = 0;
  int last_acc = 0, prev_acc = 0;
  sb_t  sb [$];
  vec_t cur;
  vec_t vecs [10];

  mmio_bus_ctrl #(.READ_LATENCY(RL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_addr     (cpu_addr),
    .cpu_write    (cpu_write),
    .cpu_wdata    (cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rdata    (cpu_rdata),
    .cpu_err      (cpu_err),
    .periph_cs    (periph_cs),
    .periph_we    (periph_we),
    .periph_wdata (periph_wdata),
    .periph_rdata (periph_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: read data valid only in the cycle after a read strobe;
  // any other cycle shows a poison pattern.
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      prd[i] <= (periph_cs[i] && !periph_we) ? rom[i] : (32'hDEAD_0000 | 32'(i));

  always_comb begin
    periph_rdata = '0;
    for (int i = 0; i < 4; i++) periph_rdata[32*i +: 32] = prd[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] cs, input logic [31:0] rd, input logic e,
                              input int lat);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = d; v.cs = cs; v.rdata = rd; v.err = e; v.lat = lat;
    return v;
  endfunction

  // Monitor / scoreboard: single process so accept detection and checking
  // never race each other.
  initial begin : mon
    bit busy;
    logic [31:0] hold_rdata;
    logic        hold_err;
    hold_rdata = '0;
    hold_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        hold_rdata = '0;
        hold_err   = 1'b0;
      end else begin
        busy = (sb.size() != 0);
        chk1("ready", cpu_req_ready, !busy);
        if (busy && cyc == sb[0].acc + 1 && sb[0].v.cs != 4'b0) begin
          chk("cs", {28'b0, periph_cs}, {28'b0, sb[0].v.cs});
          chk1("we", periph_we, sb[0].v.wr);
          chk("periph_wdata", periph_wdata, sb[0].v.wdata);
        end else begin
          chk("cs_idle", {28'b0, periph_cs}, 32'h0);
          chk1("we_idle", periph_we, 1'b0);
          chk("wdata_idle", periph_wdata, 32'h0);
        end
        if (periph_cs != 4'b0) n_cs++;
        if (cpu_rsp_valid) n_rsp++;
        if (busy && cyc == sb[0].acc + sb[0].v.lat) begin
          chk1("rsp_valid", cpu_rsp_valid, 1'b1);
          chk("rdata", cpu_rdata, sb[0].v.rdata);
          chk1("err", cpu_err, sb[0].v.err);
          hold_rdata = sb[0].v.rdata;
          hold_err   = sb[0].v.err;
          void'(sb.pop_front());
        end else begin
          chk1("rsp_idle", cpu_rsp_valid, 1'b0);
          chk("rdata_hold", cpu_rdata, hold_rdata);
          chk1("err_hold", cpu_err, hold_err);
        end
        if (cpu_req_valid && cpu_req_ready) begin
          sb.push_back('{v: cur, acc: cyc});
          prev_acc = last_acc;
          last_acc = cyc;
          n_acc++;
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cur           = v;
    cpu_req_valid = 1'b1;
    cpu_addr      = v.addr;
    cpu_write     = v.wr;
    cpu_wdata     = v.wdata;
  endtask

  task automatic wait_acc(input int tgt);
    for (int i = 0; i < 50 && n_acc < tgt; i++) @(posedge clk);
    chk1("accept_seen", n_acc >= tgt, 1'b1);
  endtask

  task automatic wait_rsp(input int tgt);
    for (int i = 0; i < 50 && n_rsp < tgt; i++) @(posedge clk);
    chk1("response_seen", n_rsp >= tgt, 1'b1);
  endtask

  task automatic run_req(input vec_t v);
    int ta, tr;
    ta = n_acc + 1;
    tr = n_rsp + 1;
    @(posedge clk); #1;
    drive(v);
    wait_acc(ta);
    #1 cpu_req_valid = 1'b0;
    wait_rsp(tr);
  endtask

  initial begin
    int c0, r0, a0;
    vec_t va, vb, vr;
    cpu_req_valid = 1'b0;
    cpu_addr      = '0;
    cpu_write     = 1'b0;
    cpu_wdata     = '0;
    cur           = mk(32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0, 1);

    vecs[0] = mk(32'hFFFF_F000, 1'b1, 32'h0000_03FF, 4'b0001, 32'h0,  1'b0, 2);
    vecs[1] = mk(32'hFFFF_F010, 1'b0, 32'h0,         4'b0010, rom[1], 1'b0, 2 + RL);
    vecs[2] = mk(32'h0000_1000, 1'b0, 32'h0,         4'b0000, 32'h0,  1'b1, 1);
    vecs[3] = mk(32'hFFFF_F034, 1'b1, 32'hFFFF_FFFF, 4'b1000, 32'h0,  1'b0, 2);
    vecs[4] = mk(32'hFFFF_F03C, 1'b0, 32'h0,         4'b1000, rom[3], 1'b0, 2 + RL);
    vecs[5] = mk(32'hFFFF_F040, 1'b0, 32'h0,         4'b0000, 32'h0,  1'b1, 1);
    vecs[6] = mk(32'hFFFF_F02C, 1'b0, 32'h1234_5678, 4'b0100, rom[2], 1'b0, 2 + RL);
    vecs[7] = mk(32'hFFFF_E020, 1'b1, 32'h0000_0077, 4'b0000, 32'h0,  1'b1, 1);
`ifdef MMIO_ALIGN_CHECK_EN
    vecs[8] = mk(32'hFFFF_F002, 1'b0, 32'h0,         4'b0000, 32'h0,  1'b1, 1);
    vecs[9] = mk(32'hFFFF_F013, 1'b1, 32'h0000_CAFE, 4'b0000, 32'h0,  1'b1, 1);
`else
    vecs[8] = mk(32'hFFFF_F002, 1'b0, 32'h0,         4'b0001, rom[0], 1'b0, 2 + RL);
    vecs[9] = mk(32'hFFFF_F013, 1'b1, 32'h0000_CAFE, 4'b0010, 32'h0,  1'b0, 2);
`endif

    // Reset state
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk1("rst_ready", cpu_req_ready, 1'b1);
    chk("rst_cs", {28'b0, periph_cs}, 32'h0);
    chk1("rst_we", periph_we, 1'b0);
    chk("rst_wdata", periph_wdata, 32'h0);
    chk1("rst_rsp", cpu_rsp_valid, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk1("rst_err", cpu_err, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_req(vecs[i]);

    // Request held valid across two stores
    va = mk(32'hFFFF_F020, 1'b1, 32'h0000_0055, 4'b0100, 32'h0, 1'b0, 2);
    vb = mk(32'hFFFF_F030, 1'b1, 32'h0000_ABCD, 4'b1000, 32'h0, 1'b0, 2);
    c0 = n_cs; r0 = n_rsp; a0 = n_acc;
    @(posedge clk); #1;
    drive(va);
    wait_acc(a0 + 1);
    #1 drive(vb);
    wait_acc(a0 + 2);
    #1 cpu_req_valid = 1'b0;
    wait_rsp(r0 + 2);
    chk("b2b_accept_gap", last_acc - prev_acc, 3);
    chk("b2b_cs_pulses", n_cs - c0, 2);
    chk("b2b_responses", n_rsp - r0, 2);

    // Reset during WAIT of a read
    vr = mk(32'hFFFF_F010, 1'b0, 32'h0, 4'b0010, rom[1], 1'b0, 2 + RL);
    r0 = n_rsp; a0 = n_acc;
    @(posedge clk); #1;
    drive(vr);
    wait_acc(a0 + 1);
    #1 cpu_req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", {28'b0, periph_cs}, 32'h0);
    chk1("rst_mid_rsp", cpu_rsp_valid, 1'b0);
    chk1("rst_mid_ready", cpu_req_ready, 1'b1);
    chk("rst_mid_rdata", cpu_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("rst_mid_no_rsp", n_rsp - r0, 0);
    run_req(vr);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Memory-mapped I/O controller between the pipeline's memory stage and the peripheral drivers (LEDs, switches, keys, ...).
- Accepts one CPU load/store request at a time and decodes the address to a peripheral slot.
- Drives a one-cycle chip_select/write_enable/data_write strobe into that peripheral.
- Collects the peripheral's registered read data and returns a single response pulse to the CPU.

Parameters:
N_PERIPH, 4, number of peripheral slots (power of two, >= 2); IDX_W = $clog2(N_PERIPH)
BASE_ADDR, 32'hFFFF_F000, base of the I/O window
SLOT_BITS, 4, log2 of bytes per slot; slot i occupies BASE_ADDR + i*2^SLOT_BITS
READ_LATENCY, 1, cycles from the strobe cycle's closing edge until peripheral read data is valid (>= 1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller can accept a request
cpu_addr  in  32  byte address
cpu_write  in  1  1 = store, 0 = load
cpu_wdata  in  32  store data
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rdata  out  32  load data, valid with cpu_rsp_valid
cpu_err  out  1  access error, valid with cpu_rsp_valid
periph_cs  out  N_PERIPH  one-hot chip selects
periph_we  out  1  write enable, shared by all slots
periph_wdata  out  32  write data, shared by all slots
periph_rdata  in  N_PERIPH*32  read data; slot i occupies bits [32i+31:32i]

Behaviour:
Reset values:
- Asynchronous, active-low: state=IDLE; periph_cs=0, periph_we=0, periph_wdata=0, cpu_rsp_valid=0, cpu_rdata=0, cpu_err=0.
- cpu_req_ready = (state==IDLE), so it reads 1 during reset.

Address decode:
- Hit when cpu_addr[31:SLOT_BITS+IDX_W] == BASE_ADDR[31:SLOT_BITS+IDX_W].
- Slot index = cpu_addr[SLOT_BITS+IDX_W-1:SLOT_BITS].
- Address bits below SLOT_BITS are ignored (subject to the optional feature).

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when cpu_req_valid and cpu_req_ready (cycle 0), register addr, write, wdata and the decode result.
  - Hit → ISSUE.
  - Miss → RESP with err=1.
- ISSUE (cycle 1): periph_cs[idx]=1 for exactly this one cycle; periph_we=write; periph_wdata=wdata.
  - Write → RESP.
  - Read → WAIT, with the latency counter loaded to READ_LATENCY.
- WAIT: decrement the counter each cycle. In the final WAIT cycle, register cpu_rdata <= periph_rdata slice [idx], then → RESP.
- RESP: cpu_rsp_valid=1 for one cycle, then → IDLE.

Latency, with accept in cycle 0:
- Unmapped access: response in cycle 1.
- Write: response in cycle 2.
- Read: response in cycle 2+READ_LATENCY (cycle 3 at the default).

Output and data rules:
- Writes and errors return cpu_rdata=0. cpu_err=0 on every successful access.
- Between responses, cpu_rdata/cpu_err hold their last value.
- periph_we and periph_wdata are 0 whenever periph_cs==0.
- No 32-bit truncation or sign handling; data passes through unchanged.

Boundary conditions:
- cpu_req_valid while busy: ignored. The CPU holds the request until ready is seen.
- Back-to-back requests: the next accept can happen at the earliest in the cycle after RESP, because IDLE has ready=1.
- Reset asserted mid-operation: periph_cs and cpu_rsp_valid drop immediately. The request is lost and no response is issued.
- Top of window (slot N_PERIPH-1): decodes normally. The address BASE_ADDR + N_PERIPH*2^SLOT_BITS is unmapped.

Optional Feature:
MMIO_ALIGN_CHECK_EN
- Defined: cpu_addr[1:0] != 0 is treated as unmapped: no chip select, response in cycle 1 with err=1 and rdata=0.
- Undefined: addr[1:0] is ignored and a misaligned address accesses its slot normally.

Decomposition:
- Package mmio_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default BASE_ADDR/SLOT_BITS/N_PERIPH, named slot indices (SLOT_LEDS=0, SLOT_SWITCHES=1, SLOT_KEYS=2, SLOT_TIMER=3).
- Sub-module mmio_addr_decode: combinational; cpu_addr → hit, index, misaligned.
- FSM and latency counter stay in the top module.

Test Plan:
- Store 0x0000_03FF to 0xFFFF_F000 → periph_cs=4'b0001 only in cycle 1, periph_we=1, periph_wdata=0x3FF; rsp_valid in cycle 2, err=0, rdata=0.
- Load from 0xFFFF_F010; slot-1 model registers 0x0000_00A5 one cycle after cs → periph_cs=4'b0010 in cycle 1; rsp_valid in cycle 3 with rdata=0xA5, err=0.
- Load from 0x0000_1000 (unmapped) → periph_cs stays 0; rsp_valid in cycle 1, err=1, rdata=0.
- cpu_req_valid held high across two stores → ready=0 from cycle 1 through RESP; second accept in the cycle after RESP; exactly two cs pulses and two responses.
- reset_n pulled low during WAIT of a read → cs/rsp_valid=0 immediately, no response; after release, a load of slot 1 completes normally in 3 cycles.
- Load from 0xFFFF_F002 → with MMIO_ALIGN_CHECK_EN: err=1 in cycle 1, no cs; without it: periph_cs=4'b0001 and a normal read.
